// File: rtl/ringosc_pkg.sv
// Shared types and constants for the ring-oscillator measurement controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ringosc_pkg;

    // Controller phases: IDLE waits for a command, SETTLE lets the oscillator
    // stabilise, GATE counts edges, DONE presents the result.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Divider select codes understood by the oscillator macro.
    localparam logic [2:0] CLKMUX_DIV1 = 3'b000;
    localparam logic [2:0] CLKMUX_DIV2 = 3'b001;
    localparam logic [2:0] CLKMUX_DIV4 = 3'b010;
    localparam logic [2:0] CLKMUX_DIV8 = 3'b011;

    localparam int DEFAULT_TRIM_BITS = 26;

    // Bits needed for a counter that must reach max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ringosc_edge_sync.sv
// Brings an asynchronous clock-like signal into clk and flags its rising edges.
// Latency: an input rise shows up as a one-cycle pulse 2-3 clk cycles later.
// Backpressure: none; the pulse is free-running and must be consumed every cycle.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset (all flops to 0)
//   async_in   asynchronous input, must toggle slower than clk/2
//   edge_pulse one-cycle pulse per rising edge of async_in
module ringosc_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_pulse
);

    logic sync1;
    logic sync2;
    logic sync3;

    // sync1/sync2 resolve metastability; sync3 is the delayed copy used only
    // for edge detection so the pulse is built from settled values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign edge_pulse = sync2 & ~sync3;

endmodule

// File: rtl/ringosc_meter.sv
// Ring-oscillator controller and frequency counter: start, settle, gate, report.
// Latency: result SETTLE_CYCLES+cmd_gate+1 clks after the accept edge.
// Backpressure: cmd_ready only in IDLE; result held in DONE until res_ready.
//
// Ports:
//   clk, rst_n                      system clock, async active-low reset
//   cmd_valid/cmd_ready             measurement request handshake
//   cmd_trim, cmd_clkmux, cmd_gate  trim code, divider select, gate length
//   cmd_cont                        continuous mode (only with RINGOSC_METER_CONT_EN)
//   abort                           synchronous cancel from any state
//   busy                            high whenever not IDLE
//   res_valid/res_ready             result handshake
//   res_count, res_sat              edge count and saturation flag
//   osc_start, osc_trim, osc_clkmux controls to the oscillator macro
//   osc_clk_in                      oscillator clock, asynchronous to clk
//
// Optional feature macro: RINGOSC_METER_CONT_EN adds back-to-back gated
// measurements without re-settling; without it the block is single-shot.
module ringosc_meter
    import ringosc_pkg::*;
#(
    parameter int TRIM_BITS     = DEFAULT_TRIM_BITS,
    parameter int GATE_W        = 16,
    parameter int COUNT_W       = 16,
    parameter int SETTLE_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [TRIM_BITS-1:0] cmd_trim,
    input  logic [2:0]           cmd_clkmux,
    input  logic [GATE_W-1:0]    cmd_gate,
`ifdef RINGOSC_METER_CONT_EN
    input  logic                 cmd_cont,
`endif
    input  logic                 abort,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [COUNT_W-1:0]   res_count,
    output logic                 res_sat,
    output logic                 osc_start,
    output logic [TRIM_BITS-1:0] osc_trim,
    output logic [2:0]           osc_clkmux,
    input  logic                 osc_clk_in
);

    localparam int SET_W = cnt_w(SETTLE_CYCLES);

    state_t              state;
    state_t              state_d;
    logic [SET_W-1:0]    settle_cnt;
    logic [GATE_W-1:0]   gate_len;
    logic [GATE_W-1:0]   gate_cnt;
    logic                cont_q;
    logic                edge_pulse;

    logic                accept;
    logic                hs;
    logic                load_win;
    logic                osc_start_d;

    ringosc_edge_sync u_edge_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (osc_clk_in),
        .edge_pulse (edge_pulse)
    );

`ifdef RINGOSC_METER_CONT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont_q <= 1'b0;
        end else if (accept) begin
            cont_q <= cmd_cont;
        end
    end
`else
    assign cont_q = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state;
        accept      = 1'b0;
        load_win    = 1'b0;
        hs          = res_valid && res_ready;
        osc_start_d = 1'b0;

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        accept  = 1'b1;
                        state_d = SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SET_W'(SETTLE_CYCLES)) begin
                        load_win = 1'b1;
                        state_d  = (gate_len == '0) ? DONE : GATE;
                    end
                end
                GATE: begin
                    // gate_cnt is loaded with a non-zero length, so reaching 1
                    // marks the final counting cycle.
                    if (gate_cnt == GATE_W'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (hs) begin
                        if (cont_q) begin
                            // Oscillator is already running: reopen the gate
                            // immediately with a fresh count.
                            load_win = 1'b1;
                            state_d  = (gate_len == '0) ? DONE : GATE;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Start rises one cycle after accept (first SETTLE->SETTLE edge),
        // stays up through the gate, and only survives DONE in continuous mode.
        osc_start_d = (state == SETTLE && state_d == SETTLE) ||
                      (state_d == GATE) ||
                      (state_d == DONE && cont_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready  <= 1'b0;
            busy       <= 1'b0;
            osc_start  <= 1'b0;
            res_valid  <= 1'b0;
            osc_trim   <= '0;
            osc_clkmux <= '0;
            gate_len   <= '0;
            settle_cnt <= '0;
            gate_cnt   <= '0;
            res_count  <= '0;
            res_sat    <= 1'b0;
        end else begin
            cmd_ready <= (state_d == IDLE);
            busy      <= (state_d != IDLE);
            osc_start <= osc_start_d;
            // Dropping on the handshake lets a DONE->DONE re-entry present a
            // new result rather than appearing to hold the consumed one.
            res_valid <= (state_d == DONE) && !hs;

            if (accept) begin
                osc_trim   <= cmd_trim;
                osc_clkmux <= cmd_clkmux;
                gate_len   <= cmd_gate;
            end

            settle_cnt <= (state == SETTLE && state_d == SETTLE) ?
                          settle_cnt + SET_W'(1) : '0;

            if (state_d == IDLE) begin
                gate_cnt  <= '0;
                res_count <= '0;
                res_sat   <= 1'b0;
            end else if (load_win) begin
                gate_cnt  <= gate_len;
                res_count <= '0;
                res_sat   <= 1'b0;
            end else if (state == GATE) begin
                gate_cnt <= gate_cnt - GATE_W'(1);
                if (edge_pulse) begin
                    if (res_count == '1) begin
                        res_sat <= 1'b1;
                    end else begin
                        res_count <= res_count + COUNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ringosc_meter.sv
// Self-checking bench for ringosc_meter: a timeline model predicts every output
// each cycle; directed cases pin the model with hand-computed values.
// A second instance with a 4-bit counter shares all stimulus to exercise saturation.
module tb_ringosc_meter;
    import ringosc_pkg::*;

    localparam int S = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [25:0] cmd_trim = '0;
    logic [2:0]  cmd_clkmux = '0;
    logic [15:0] cmd_gate = '0;
`ifdef RINGOSC_METER_CONT_EN
    logic        cmd_cont = 1'b0;
`endif
    logic        abort = 1'b0;
    logic        res_ready = 1'b0;
    logic        osc_clk_in = 1'b0;

    logic        cmd_ready, busy, res_valid, res_sat, osc_start;
    logic [15:0] res_count;
    logic [25:0] osc_trim;
    logic [2:0]  osc_clkmux;

    logic        s_cmd_ready, s_busy, s_res_valid, s_res_sat, s_osc_start;
    logic [3:0]  s_res_count;
    logic [25:0] s_osc_trim;
    logic [2:0]  s_osc_clkmux;

    ringosc_meter #(.TRIM_BITS(26), .GATE_W(16), .COUNT_W(16), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_trim(cmd_trim), .cmd_clkmux(cmd_clkmux), .cmd_gate(cmd_gate),
`ifdef RINGOSC_METER_CONT_EN
        .cmd_cont(cmd_cont),
`endif
        .abort(abort), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_count(res_count), .res_sat(res_sat), .osc_start(osc_start),
        .osc_trim(osc_trim), .osc_clkmux(osc_clkmux), .osc_clk_in(osc_clk_in)
    );

    ringosc_meter #(.TRIM_BITS(26), .GATE_W(16), .COUNT_W(4), .SETTLE_CYCLES(S)) dut_s (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
        .cmd_trim(cmd_trim), .cmd_clkmux(cmd_clkmux), .cmd_gate(cmd_gate),
`ifdef RINGOSC_METER_CONT_EN
        .cmd_cont(cmd_cont),
`endif
        .abort(abort), .busy(s_busy), .res_valid(s_res_valid), .res_ready(res_ready),
        .res_count(s_res_count), .res_sat(s_res_sat), .osc_start(s_osc_start),
        .osc_trim(s_osc_trim), .osc_clkmux(s_osc_clkmux), .osc_clk_in(osc_clk_in)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Oscillator source: fixed period (in clk cycles) or random half-periods.
    // Changes land on clk negedges so every posedge samples a stable value.
    // ------------------------------------------------------------------
    int osc_p = 10;
    bit osc_rand = 1'b0;
    initial begin
        int ph = 0;
        int rem = 1;
        forever begin
            @(negedge clk);
            if (osc_rand) begin
                if (rem <= 1) begin
                    osc_clk_in = ~osc_clk_in;
                    rem = $urandom_range(1, 6);
                end else begin
                    rem--;
                end
            end else begin
                ph = ph + 1;
                if (ph >= osc_p) ph = 0;
                osc_clk_in = (ph < osc_p / 2);
            end
        end
    end

    // res_ready: fixed level or random per cycle.
    bit rr_rand = 1'b0;
    bit rr_val  = 1'b1;
    initial forever begin
        @(negedge clk);
        res_ready = rr_rand ? ($urandom_range(0, 2) != 0) : rr_val;
    end

    // ------------------------------------------------------------------
    // Timeline model. A job is described by its accept edge a, gate-open
    // edge ws and result edge we; outputs follow from where "now" falls.
    // Edges counted at edge m are rises seen in the samples at m-3 -> m-2.
    // ------------------------------------------------------------------
    int cyc = 0;
    bit samp [0:131071];
    bit m_active = 0, m_ready_ok = 0, m_cont = 0;
    int m_a = 0, m_ws = 0, m_we = 0, m_gate = 0;
    logic [25:0] e_trim = '0;
    logic [2:0]  e_mux = '0;
    bit e_busy = 0, e_ready = 0, e_start = 0, e_valid = 0, e_sat = 0, e_sat_s = 0;
    int e_count = 0, e_count_s = 0;

    function automatic int window_edges(input int ws, input int we);
        int n = 0;
        for (int m = ws + 1; m <= we; m++)
            if (samp[m-2] && !samp[m-3]) n++;
        return n;
    endfunction

    initial begin
        int n;
        forever begin
            @(posedge clk);
            cyc++;
            if (cyc > 131000) begin
                $display("FAIL cycle_budget: got %0d cycles, expected fewer", cyc);
                $fatal(1);
            end
            samp[cyc] = osc_clk_in;
            if (!rst_n) begin
                m_active = 0; m_ready_ok = 0; e_trim = '0; e_mux = '0;
            end else begin
                if (abort) begin
                    m_active = 0;
                end else if (!m_active) begin
                    if (m_ready_ok && cmd_valid) begin
                        m_active = 1; m_a = cyc; m_gate = int'(cmd_gate);
                        m_ws = cyc + S + 1; m_we = m_ws + m_gate;
                        e_trim = cmd_trim; e_mux = cmd_clkmux;
`ifdef RINGOSC_METER_CONT_EN
                        m_cont = cmd_cont;
`else
                        m_cont = 0;
`endif
                    end
                end else if (e_valid && res_ready) begin
                    if (m_cont) begin
                        m_ws = cyc; m_we = cyc + m_gate;
                    end else begin
                        m_active = 0;
                    end
                end
                m_ready_ok = 1;
            end
            e_busy  = m_active;
            e_ready = m_ready_ok && !m_active;
            e_start = m_active && (cyc > m_a) && (m_cont || cyc < m_we);
            e_valid = m_active && (cyc >= m_we);
            if (e_valid && cyc == m_we) begin
                n = window_edges(m_ws, m_we);
                e_count   = (n > 65535) ? 65535 : n;
                e_sat     = (n > 65535);
                e_count_s = (n > 15) ? 15 : n;
                e_sat_s   = (n > 15);
            end
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        chk("busy", busy, e_busy);
        chk("cmd_ready", cmd_ready, e_ready);
        chk("osc_start", osc_start, e_start);
        chk("res_valid", res_valid, e_valid);
        chk("osc_trim", osc_trim, e_trim);
        chk("osc_clkmux", osc_clkmux, e_mux);
        chk("s_busy", s_busy, e_busy);
        chk("s_cmd_ready", s_cmd_ready, e_ready);
        chk("s_osc_start", s_osc_start, e_start);
        chk("s_res_valid", s_res_valid, e_valid);
        chk("s_osc_trim", s_osc_trim, e_trim);
        chk("s_osc_clkmux", s_osc_clkmux, e_mux);
        if (e_valid) begin
            chk("res_count", res_count, e_count);
            chk("res_sat", res_sat, e_sat);
            chk("s_res_count", s_res_count, e_count_s);
            chk("s_res_sat", s_res_sat, e_sat_s);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (always entered right after a negedge)
    // ------------------------------------------------------------------
    task automatic issue(input logic [25:0] t, input logic [2:0] m, input logic [15:0] g);
        int k = 0;
        while (!cmd_ready && k < 5000) begin @(negedge clk); k++; end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_trim = t; cmd_clkmux = m; cmd_gate = g; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Waits for res_valid, counting cycles osc_start was high on the way.
    task automatic wait_valid(output int hi);
        int k = 0;
        hi = 0;
        while (!res_valid && k < 5000) begin
            if (osc_start) hi++;
            @(negedge clk); k++;
        end
        chk("res_valid_wait", res_valid, 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 5000) begin @(negedge clk); k++; end
        chk("idle_wait", busy, 0);
    endtask

    initial begin
        int hi;
        logic [15:0] held;

        // Reset
        repeat (2) @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_osc_start", osc_start, 0);
        chk("reset_res_valid", res_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", cmd_ready, 1);
        chk("busy_after_reset", busy, 0);

        // Period 10, gate 1000: ~100 edges, start high for S+1000 cycles
        osc_p = 10; rr_val = 1'b1;
        issue(26'h2A5A5A5, CLKMUX_DIV2, 16'd1000);
        chk("trim_on_accept", osc_trim, 26'h2A5A5A5);
        chk("clkmux_on_accept", osc_clkmux, CLKMUX_DIV2);
        wait_valid(hi);
        chk("start_high_cycles", hi, S + 1000);
        chk_rng("count_p10_g1000", int'(res_count), 99, 101);
        chk("sat_p10_g1000", res_sat, 0);
        chk("start_low_done", osc_start, 0);
        wait_idle();

        // Period 4, gate 200: 50 edges; 4-bit instance saturates at 15
        osc_p = 4;
        issue(26'h0000123, CLKMUX_DIV1, 16'd200);
        wait_valid(hi);
        chk("sat4_count", s_res_count, 15);
        chk("sat4_flag", s_res_sat, 1);
        chk_rng("wide_count_p4", int'(res_count), 49, 51);
        wait_idle();

        // Zero gate: result straight after settle, count 0
        issue(26'h3FFFFFF, CLKMUX_DIV8, 16'd0);
        wait_valid(hi);
        chk("gate0_start_cycles", hi, S);
        chk("gate0_count", res_count, 0);
        chk("gate0_start_low", osc_start, 0);
        wait_idle();

        // Abort mid-gate, then a normal measurement
        osc_p = 7;
        issue(26'h1555555, CLKMUX_DIV4, 16'd600);
        repeat (S + 1 + 200) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_start", osc_start, 0);
        chk("abort_valid", res_valid, 0);
        chk("abort_ready", cmd_ready, 1);
        chk("abort_trim_kept", osc_trim, 26'h1555555);
        osc_p = 6;
        issue(26'h0ABCDEF, CLKMUX_DIV2, 16'd300);
        wait_valid(hi);
        chk_rng("after_abort_count", int'(res_count), 49, 51);
        wait_idle();

        // abort with cmd_valid in IDLE: not accepted
        abort = 1'b1; cmd_valid = 1'b1;
        @(negedge clk);
        abort = 1'b0; cmd_valid = 1'b0;
        chk("abort_blocks_cmd", busy, 0);

        // Result stalled 50 cycles
        rr_val = 1'b0; osc_p = 8;
        issue(26'h0000F0F, CLKMUX_DIV1, 16'd100);
        wait_valid(hi);
        held = res_count;
        chk_rng("stall_count", int'(held), 11, 13);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i % 10 == 9) begin
                chk("stall_valid", res_valid, 1);
                chk("stall_count_held", res_count, held);
                chk("stall_ready_low", cmd_ready, 0);
            end
        end
        rr_val = 1'b1;
        wait_idle();
        @(negedge clk);
        chk("ready_after_handshake", cmd_ready, 1);

`ifdef RINGOSC_METER_CONT_EN
        // Continuous mode: three results, gate reopened without settle
        begin
            int nres = 0, k = 0, last = 0, drops = 0;
            osc_p = 5; cmd_cont = 1'b1;
            issue(26'h0222222, CLKMUX_DIV2, 16'd500);
            cmd_cont = 1'b0;
            repeat (S + 2) @(negedge clk);
            while (nres < 3 && k < 5000) begin
                if (!osc_start) drops++;
                if (res_valid) begin
                    chk_rng("cont_count", int'(res_count), 99, 101);
                    if (nres > 0) chk("cont_interval", k - last, 501);
                    last = k; nres++;
                end
                @(negedge clk); k++;
            end
            chk("cont_results", nres, 3);
            chk("cont_start_drops", drops, 0);
            chk("cont_ready_low", cmd_ready, 0);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("cont_abort_busy", busy, 0);
            chk("cont_abort_start", osc_start, 0);
        end
`endif

        // Randomized: irregular oscillator, random res_ready, random aborts,
        // stray cmd_valid while busy
        osc_rand = 1'b1; rr_rand = 1'b1;
        for (int it = 0; it < 25; it++) begin
            issue(26'($urandom), 3'($urandom_range(0, 7)), 16'($urandom_range(0, 150)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 250)) begin
                    cmd_valid = ($urandom_range(0, 7) == 0);
                    @(negedge clk);
                end
                cmd_valid = 1'b0;
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
            end else begin
                wait_idle();
            end
        end
        wait_idle();
        rr_rand = 1'b0; osc_rand = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
